// File: rtl/router_pkg.sv
// Shared types and constants for the 4x4 router request/return path.
package router_pkg;

  localparam int unsigned NUM_MASTERS = 4;
  localparam int unsigned RD_MAX      = 8;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned TAG_W       = 3;
  localparam int unsigned TO_W        = 8;
  localparam int unsigned RESP_W      = 7;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_t;

  // Response address carried with a read so the return path can route its data.
  typedef struct packed {
    logic [1:0]       master;
    logic [1:0]       slave;
    logic [TAG_W-1:0] tag;
  } resp_addr_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority encoder: first eligible index after 'last', wrapping mod 4.
module rr_pick4
  import router_pkg::*;
(
  input  logic [3:0] elig,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Scan from lowest to highest priority so the nearest eligible index wins.
  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (elig[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/slave_req_scheduler.sv
// Per-slave round-robin request scheduler with read tagging, outstanding-read
// cap and slave handshake timeout.
module slave_req_scheduler
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned SLAVE_N     = 0,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_MASTERS-1:0]                  m_req,
  input  logic [NUM_MASTERS-1:0]                  m_cmd,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  m_addr,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata,
  output logic [NUM_MASTERS-1:0]                  m_ack,
  output logic                                    s_req,
  output logic                                    s_cmd,
  output logic [ADDR_WIDTH-1:0]                   s_addr,
  output logic [DATA_WIDTH-1:0]                   s_wdata,
  output logic [RESP_W-1:0]                       s_tag,
  input  logic                                    s_ack,
  input  logic [NUM_MASTERS-1:0]                  rd_done,
  output logic                                    err_timeout
);

  sched_state_t                            state_q, state_d;
  logic [1:0]                              grant_q, grant_d;
  logic [1:0]                              last_q, last_d;
  logic [TO_W-1:0]                         to_cnt_q, to_cnt_d;
  logic [NUM_MASTERS-1:0][CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic [NUM_MASTERS-1:0][TAG_W-1:0]       tag_ptr_q, tag_ptr_d;

  logic [NUM_MASTERS-1:0]                  m_ack_d;
  logic                                    s_req_d, s_cmd_d, err_d;
  logic [ADDR_WIDTH-1:0]                   s_addr_d;
  logic [DATA_WIDTH-1:0]                   s_wdata_d;
  logic [RESP_W-1:0]                       s_tag_d;
  resp_addr_t                              tag_w;

  logic [NUM_MASTERS-1:0]                  elig;
  logic [NUM_MASTERS-1:0]                  issue_rd;
  logic [NUM_MASTERS-1:0]                  to_rel;
  logic                                    pick_valid;
  logic [1:0]                              pick_idx;
  logic [NUM_MASTERS-1:0][CNT_W:0]         sum_c, sub_c;

  // A master may compete if it writes, or reads with a free outstanding slot.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      elig[i] = m_req[i] && (m_cmd[i] || (rd_cnt_q[i] < CNT_W'(RD_MAX)));
    end
  end

  rr_pick4 u_pick (
    .elig  (elig),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state and next-output logic for the grant/issue handshake.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    to_cnt_d  = to_cnt_q;
    m_ack_d   = '0;
    err_d     = 1'b0;
    s_req_d   = s_req;
    s_cmd_d   = s_cmd;
    s_addr_d  = s_addr;
    s_wdata_d = s_wdata;
    s_tag_d   = s_tag;
    issue_rd  = '0;
    to_rel    = '0;
    tag_w     = '0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d           = ISSUE;
          grant_d           = pick_idx;
          last_d            = pick_idx;
          to_cnt_d          = '0;
          m_ack_d[pick_idx] = 1'b1;
          s_req_d           = 1'b1;
          s_cmd_d           = m_cmd[pick_idx];
          s_addr_d          = m_addr[pick_idx];
          s_wdata_d         = m_wdata[pick_idx];
          s_tag_d           = '0;
          if (!m_cmd[pick_idx]) begin
            tag_w.master       = pick_idx;
            tag_w.slave        = 2'(SLAVE_N);
            tag_w.tag          = tag_ptr_q[pick_idx];
            s_tag_d            = tag_w;
            issue_rd[pick_idx] = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (s_ack) begin
          state_d  = IDLE;
          s_req_d  = 1'b0;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
          // Abandon the command; a timed-out read gives its slot back.
          state_d  = IDLE;
          s_req_d  = 1'b0;
          to_cnt_d = '0;
          err_d    = 1'b1;
          if (!s_cmd) begin
            to_rel[grant_q] = 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding-read counters and tag pointers; releases saturate at zero.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    tag_ptr_d = tag_ptr_q;
    sum_c     = '0;
    sub_c     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sum_c[i]     = (CNT_W+1)'(rd_cnt_q[i]) + (CNT_W+1)'(issue_rd[i]);
      sub_c[i]     = (CNT_W+1)'(rd_done[i] && (rd_cnt_q[i] != '0))
                   + (CNT_W+1)'(to_rel[i]);
      rd_cnt_d[i]  = (sum_c[i] < sub_c[i]) ? '0 : CNT_W'(sum_c[i] - sub_c[i]);
      tag_ptr_d[i] = tag_ptr_q[i] + TAG_W'(issue_rd[i]);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= 2'd3;
      to_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      tag_ptr_q   <= '0;
      m_ack       <= '0;
      s_req       <= 1'b0;
      s_cmd       <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_tag       <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      to_cnt_q    <= to_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      tag_ptr_q   <= tag_ptr_d;
      m_ack       <= m_ack_d;
      s_req       <= s_req_d;
      s_cmd       <= s_cmd_d;
      s_addr      <= s_addr_d;
      s_wdata     <= s_wdata_d;
      s_tag       <= s_tag_d;
      err_timeout <= err_d;
    end
  end

endmodule

// File: tb/tb_slave_req_scheduler.sv
// Directed bench for slave_req_scheduler (SLAVE_N=0, ACK_TIMEOUT=4).
module tb_slave_req_scheduler;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       m_req, m_cmd, m_ack, rd_done;
  logic [3:0][AW-1:0] m_addr;
  logic [3:0][DW-1:0] m_wdata;
  logic             s_req, s_cmd, s_ack, err_timeout;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [6:0]       s_tag;

  int n_vec = 0;
  int n_err = 0;

  slave_req_scheduler #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .SLAVE_N    (0),
    .ACK_TIMEOUT(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_req       (m_req),
    .m_cmd       (m_cmd),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_ack       (m_ack),
    .s_req       (s_req),
    .s_cmd       (s_cmd),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_tag       (s_tag),
    .s_ack       (s_ack),
    .rd_done     (rd_done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".s_req"}, 64'(s_req), 64'd0);
    chk({tag, ".m_ack"}, 64'(m_ack), 64'd0);
    chk({tag, ".s_tag"}, 64'(s_tag), 64'd0);
    chk({tag, ".s_addr"}, 64'(s_addr), 64'd0);
    chk({tag, ".err"}, 64'(err_timeout), 64'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    m_req   = '0;
    m_cmd   = '0;
    rd_done = '0;
    s_ack   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_addr[i]  = AW'(32'h100 + i);
      m_wdata[i] = DW'(32'hA0 + i);
    end
    do_reset();
    chk_idle_outputs("reset");

    // Round robin after reset: grants 0,1,2,3,0 with tags 00,20,40,60,01.
    begin
      logic [3:0] exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [6:0] exp_tag [5] = '{7'h00, 7'h20, 7'h40, 7'h60, 7'h01};
      logic [31:0] exp_adr [5] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h100};
      m_req = 4'b1111;
      m_cmd = 4'b0000;
      s_ack = 1'b1;
      for (int g = 0; g < 5; g++) begin
        tick();
        chk("rr.m_ack", 64'(m_ack), 64'(exp_ack[g]));
        chk("rr.s_tag", 64'(s_tag), 64'(exp_tag[g]));
        chk("rr.s_addr", 64'(s_addr), 64'(exp_adr[g]));
        chk("rr.s_req", 64'(s_req), 64'd1);
        tick();
        chk("rr.s_req_drop", 64'(s_req), 64'd0);
      end
      m_req = '0;
    end

    // Release slots (m0 holds 2, others 1), then a stray rd_done on an empty count.
    rd_done = 4'b1111; tick();
    rd_done = 4'b0001; tick();
    chk("rel.cnt0", 64'(dut.rd_cnt_q[0]), 64'd0);
    chk("rel.cnt3", 64'(dut.rd_cnt_q[3]), 64'd0);
    rd_done = 4'b0001; tick();
    rd_done = 4'b0000;
    chk("stray.cnt0", 64'(dut.rd_cnt_q[0]), 64'd0);

    // Outstanding cap on master 2.
    do_reset();
    s_ack = 1'b1;
    m_req = 4'b0100;
    m_cmd = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("cap.m_ack", 64'(m_ack), 64'b0100);
      chk("cap.s_tag", 64'(s_tag), 64'(7'h40 + k));
      tick();
    end
    chk("cap.cnt_full", 64'(dut.rd_cnt_q[2]), 64'd8);
    tick();
    chk("cap.block_ack", 64'(m_ack), 64'd0);
    chk("cap.block_req", 64'(s_req), 64'd0);
    tick();
    chk("cap.block_ack2", 64'(m_ack), 64'd0);
    m_cmd = 4'b0100;
    tick();
    chk("cap.wr_ack", 64'(m_ack), 64'b0100);
    chk("cap.wr_cmd", 64'(s_cmd), 64'd1);
    chk("cap.wr_tag", 64'(s_tag), 64'd0);
    chk("cap.wr_data", 64'(s_wdata), 64'h A2);
    tick();
    m_cmd   = 4'b0000;
    rd_done = 4'b0100;
    tick();
    rd_done = 4'b0000;
    chk("cap.still_blocked", 64'(m_ack), 64'd0);
    tick();
    chk("cap.ninth_ack", 64'(m_ack), 64'b0100);
    chk("cap.ninth_tag", 64'(s_tag), 64'h40);
    tick();
    m_req = '0;

    // Timeout with ACK_TIMEOUT=4 on a read from master 0.
    do_reset();
    s_ack = 1'b0;
    m_req = 4'b0001;
    tick();
    chk("to.m_ack", 64'(m_ack), 64'b0001);
    m_req = '0;
    for (int c = 0; c < 3; c++) begin
      chk("to.s_req_hi", 64'(s_req), 64'd1);
      chk("to.no_err", 64'(err_timeout), 64'd0);
      tick();
    end
    chk("to.s_req_hi4", 64'(s_req), 64'd1);
    tick();
    chk("to.err", 64'(err_timeout), 64'd1);
    chk("to.s_req_lo", 64'(s_req), 64'd0);
    chk("to.cnt0", 64'(dut.rd_cnt_q[0]), 64'd0);
    s_ack = 1'b1;
    m_req = 4'b1111;
    tick();
    chk("to.err_clear", 64'(err_timeout), 64'd0);
    chk("to.next_grant", 64'(m_ack), 64'b0010);
    chk("to.next_tag", 64'(s_tag), 64'h20);

    // Build rd_cnt[1]=3, then overlap issue and release on master 1.
    m_req = 4'b0010;
    tick();
    tick(); chk("sim.tag21", 64'(s_tag), 64'h21);
    tick();
    tick(); chk("sim.tag22", 64'(s_tag), 64'h22);
    tick();
    chk("sim.cnt3", 64'(dut.rd_cnt_q[1]), 64'd3);
    rd_done = 4'b0010;
    tick();
    rd_done = 4'b0000;
    chk("sim.ack", 64'(m_ack), 64'b0010);
    chk("sim.tag23", 64'(s_tag), 64'h23);
    chk("sim.cnt_same", 64'(dut.rd_cnt_q[1]), 64'd3);
    // Let this read time out while another slot returns in the same cycle.
    s_ack = 1'b0;
    m_req = '0;
    repeat (3) tick();
    rd_done = 4'b0010;
    tick();
    rd_done = 4'b0000;
    chk("sim.to_err", 64'(err_timeout), 64'd1);
    chk("sim.to_cnt", 64'(dut.rd_cnt_q[1]), 64'd1);
    // Master 0 tag pointer was not rewound by its timeout.
    s_ack = 1'b1;
    m_req = 4'b0001;
    tick();
    chk("sim.m0_ack", 64'(m_ack), 64'b0001);
    chk("sim.m0_tag", 64'(s_tag), 64'h01);
    m_req = '0;
    tick();

    // Asynchronous reset during ISSUE.
    s_ack = 1'b0;
    m_req = 4'b0100;
    tick();
    chk("rst.s_req_before", 64'(s_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.s_req_async", 64'(s_req), 64'd0);
    tick();
    chk("rst.no_err", 64'(err_timeout), 64'd0);
    tick();
    rst_n = 1'b1;
    m_req = '0;
    chk_idle_outputs("rst.after");
    m_req = 4'b1111;
    s_ack = 1'b1;
    tick();
    chk("rst.first_grant", 64'(m_ack), 64'b0001);
    chk("rst.first_tag", 64'(s_tag), 64'h00);
    m_req = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
